// File: rtl/temp_pkg.sv
// Shared temperature types, range limits and alarm state codes used by the
// sample register, the alarm monitor and its extremes tracker.
package temp_pkg;

    typedef logic signed [10:0] temp_t;

    localparam temp_t TEMP_MIN   = temp_t'(-400);
    localparam temp_t TEMP_MAX   = temp_t'(850);
    localparam temp_t TEMP_RESET = temp_t'(220);

    typedef enum logic [2:0] {
        NORMAL    = 3'd0,
        CONF_ALTA = 3'd1,
        ALTA      = 3'd2,
        CONF_BAJA = 3'd3,
        BAJA      = 3'd4,
        FALLA     = 3'd5
    } estado_alarma_t;

    function automatic logic en_rango(input temp_t t);
        return (t >= TEMP_MIN) && (t <= TEMP_MAX);
    endfunction

endpackage

// File: rtl/registro_extremos.sv
// Running maximum/minimum of in-range samples, with a synchronous clear that
// reloads both trackers from the current sample (or the reset value).
module registro_extremos
    import temp_pkg::*;
(
    input  logic  clk,
    input  logic  arst_n,
    input  logic  muestra_en_i,
    input  temp_t temp_i,
    input  logic  borrar_i,
    output temp_t max_o,
    output temp_t min_o
);

    temp_t max_q, max_d;
    temp_t min_q, min_d;
    logic  rango;

    assign rango = en_rango(temp_i);

    // Clear wins over a simultaneous strobe; out-of-range samples never reach the trackers.
    always_comb begin
        max_d = max_q;
        min_d = min_q;
        if (borrar_i) begin
            max_d = rango ? temp_i : TEMP_RESET;
            min_d = rango ? temp_i : TEMP_RESET;
        end else if (muestra_en_i && rango) begin
            if (temp_i > max_q) max_d = temp_i;
            if (temp_i < min_q) min_d = temp_i;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            max_q <= TEMP_RESET;
            min_q <= TEMP_RESET;
        end else begin
            max_q <= max_d;
            min_q <= min_d;
        end
    end

    assign max_o = max_q;
    assign min_o = min_q;

endmodule

// File: rtl/alarma_temp.sv
// Temperature alarm monitor: high/low alarms with hysteresis and N-sample
// confirmation, sensor-fault detection, and max/min tracking.
module alarma_temp
    import temp_pkg::*;
#(
    parameter int UMBRAL_ALTO = 500,
    parameter int UMBRAL_BAJO = 0,
    parameter int HISTERESIS  = 20,
    parameter int N_CONFIRM   = 4
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       muestra_en,
    input  temp_t      temp_in,
    input  logic       borrar_extremos,
    output logic       alarma_alta,
    output logic       alarma_baja,
    output logic       falla_sensor,
    output logic [2:0] estado,
    output temp_t      temp_max,
    output temp_t      temp_min
);

    if ((UMBRAL_BAJO < -400) || (UMBRAL_ALTO > 850) ||
        (UMBRAL_BAJO + HISTERESIS >= UMBRAL_ALTO - HISTERESIS) ||
        (N_CONFIRM < 2) || (N_CONFIRM > 15)) begin : g_param_invalido
        $error("alarma_temp: illegal threshold/hysteresis/N_CONFIRM combination");
    end

    // 12-bit signed thresholds: threshold +/- hysteresis cannot overflow.
    localparam logic signed [11:0] ALTO     = 12'(UMBRAL_ALTO);
    localparam logic signed [11:0] ALTO_REL = 12'(UMBRAL_ALTO - HISTERESIS);
    localparam logic signed [11:0] BAJO     = 12'(UMBRAL_BAJO);
    localparam logic signed [11:0] BAJO_REL = 12'(UMBRAL_BAJO + HISTERESIS);
    localparam logic [3:0]         N_FIN    = 4'(N_CONFIRM);

    estado_alarma_t    estado_q, estado_d;
    logic [3:0]        cnt_q, cnt_d, cnt_inc;
    logic              alta_q, baja_q, falla_q;
    logic signed [11:0] t_ext;
    logic              rango, sobre_alto, bajo_bajo;

    assign t_ext      = {temp_in[10], temp_in};
    assign rango      = en_rango(temp_in);
    assign sobre_alto = (t_ext >= ALTO);
    assign bajo_bajo  = (t_ext <= BAJO);
    assign cnt_inc    = cnt_q + 4'd1;

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        if (muestra_en) begin
            if (!rango) begin
                estado_d = FALLA;
                cnt_d    = '0;
            end else begin
                case (estado_q)
                    NORMAL: begin
                        if (sobre_alto) begin
                            estado_d = CONF_ALTA;
                            cnt_d    = 4'd1;
                        end else if (bajo_bajo) begin
                            estado_d = CONF_BAJA;
                            cnt_d    = 4'd1;
                        end
                    end
                    CONF_ALTA: begin
                        if (!sobre_alto) begin
                            estado_d = NORMAL;
                            cnt_d    = '0;
                        end else if (cnt_inc == N_FIN) begin
                            estado_d = ALTA;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    CONF_BAJA: begin
                        if (!bajo_bajo) begin
                            estado_d = NORMAL;
                            cnt_d    = '0;
                        end else if (cnt_inc == N_FIN) begin
                            estado_d = BAJA;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    ALTA: begin
                        if (t_ext < ALTO_REL) begin
                            estado_d = NORMAL;
                            cnt_d    = '0;
                        end
                    end
                    BAJA: begin
                        if (t_ext > BAJO_REL) begin
                            estado_d = NORMAL;
                            cnt_d    = '0;
                        end
                    end
                    FALLA: begin
                        if (cnt_inc == N_FIN) begin
                            estado_d = NORMAL;
                            cnt_d    = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    default: begin
                        estado_d = NORMAL;
                        cnt_d    = '0;
                    end
                endcase
            end
        end
    end

    // Flags are registered alongside the state so they always match it exactly.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            estado_q <= NORMAL;
            cnt_q    <= '0;
            alta_q   <= 1'b0;
            baja_q   <= 1'b0;
            falla_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            alta_q   <= (estado_d == ALTA);
            baja_q   <= (estado_d == BAJA);
            falla_q  <= (estado_d == FALLA);
        end
    end

    assign estado       = estado_q;
    assign alarma_alta  = alta_q;
    assign alarma_baja  = baja_q;
    assign falla_sensor = falla_q;

    registro_extremos u_extremos (
        .clk          (clk),
        .arst_n       (arst_n),
        .muestra_en_i (muestra_en),
        .temp_i       (temp_in),
        .borrar_i     (borrar_extremos),
        .max_o        (temp_max),
        .min_o        (temp_min)
    );

endmodule

// File: tb/tb_alarma_temp.sv
// Directed bench for alarma_temp with default parameters: confirmation,
// hysteresis, low side, sensor fault, async reset, extremes and strobe gating.
module tb_alarma_temp;
    import temp_pkg::*;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       muestra_en;
    temp_t      temp_in;
    logic       borrar_extremos;
    logic       alarma_alta, alarma_baja, falla_sensor;
    logic [2:0] estado;
    temp_t      temp_max, temp_min;

    int n_cmp = 0;
    int n_err = 0;

    alarma_temp #(
        .UMBRAL_ALTO (500),
        .UMBRAL_BAJO (0),
        .HISTERESIS  (20),
        .N_CONFIRM   (4)
    ) dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .muestra_en      (muestra_en),
        .temp_in         (temp_in),
        .borrar_extremos (borrar_extremos),
        .alarma_alta     (alarma_alta),
        .alarma_baja     (alarma_baja),
        .falla_sensor    (falla_sensor),
        .estado          (estado),
        .temp_max        (temp_max),
        .temp_min        (temp_min)
    );

    always #5 clk = ~clk;

    task automatic muestra(input int v);
        muestra_en = 1'b1;
        temp_in    = temp_t'(v);
        @(posedge clk);
        #1;
        muestra_en = 1'b0;
    endtask

    task automatic test_reset;
        arst_n = 1'b1; muestra_en = 1'b0; borrar_extremos = 1'b0; temp_in = '0;
        #1 arst_n = 1'b0;
        #1;
        n_cmp++; if (estado !== 3'd0) begin n_err++; $display("FAIL reset_estado got=%0d exp=0", estado); end
        n_cmp++; if ({alarma_alta, alarma_baja, falla_sensor} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=000", {alarma_alta, alarma_baja, falla_sensor}); end
        n_cmp++; if (temp_max !== 11'sd220 || temp_min !== 11'sd220) begin n_err++; $display("FAIL reset_extremos got=%0d/%0d exp=220/220", temp_max, temp_min); end
        @(posedge clk); @(posedge clk); #1 arst_n = 1'b1;
    endtask

    task automatic test_confirmacion;
        for (int i = 1; i <= 3; i++) begin
            muestra(510);
            n_cmp++; if (estado !== 3'd1 || alarma_alta !== 1'b0) begin n_err++; $display("FAIL conf_alta_%0d got=%0d/%b exp=1/0", i, estado, alarma_alta); end
        end
        muestra(510);
        n_cmp++; if (estado !== 3'd2 || alarma_alta !== 1'b1) begin n_err++; $display("FAIL conf_alta_4 got=%0d/%b exp=2/1", estado, alarma_alta); end
    endtask

    task automatic test_histeresis;
        muestra(485);
        n_cmp++; if (estado !== 3'd2 || alarma_alta !== 1'b1) begin n_err++; $display("FAIL hist_485 got=%0d/%b exp=2/1", estado, alarma_alta); end
        muestra(480);
        n_cmp++; if (estado !== 3'd2 || alarma_alta !== 1'b1) begin n_err++; $display("FAIL hist_480 got=%0d/%b exp=2/1", estado, alarma_alta); end
        muestra(479);
        n_cmp++; if (estado !== 3'd0 || alarma_alta !== 1'b0) begin n_err++; $display("FAIL hist_479 got=%0d/%b exp=0/0", estado, alarma_alta); end
    endtask

    task automatic test_aborto;
        for (int i = 1; i <= 3; i++) begin
            muestra(510);
            n_cmp++; if (alarma_alta !== 1'b0) begin n_err++; $display("FAIL aborto_alta_%0d got=%b exp=0", i, alarma_alta); end
        end
        muestra(490);
        n_cmp++; if (estado !== 3'd0 || alarma_alta !== 1'b0) begin n_err++; $display("FAIL aborto_490 got=%0d/%b exp=0/0", estado, alarma_alta); end
    endtask

    task automatic test_baja;
        for (int i = 1; i <= 3; i++) begin
            muestra(-5);
            n_cmp++; if (estado !== 3'd3 || alarma_baja !== 1'b0) begin n_err++; $display("FAIL conf_baja_%0d got=%0d/%b exp=3/0", i, estado, alarma_baja); end
        end
        muestra(-5);
        n_cmp++; if (estado !== 3'd4 || alarma_baja !== 1'b1) begin n_err++; $display("FAIL conf_baja_4 got=%0d/%b exp=4/1", estado, alarma_baja); end
        muestra(20);
        n_cmp++; if (estado !== 3'd4 || alarma_baja !== 1'b1) begin n_err++; $display("FAIL baja_hist_20 got=%0d/%b exp=4/1", estado, alarma_baja); end
        muestra(21);
        n_cmp++; if (estado !== 3'd0 || alarma_baja !== 1'b0) begin n_err++; $display("FAIL baja_hist_21 got=%0d/%b exp=0/0", estado, alarma_baja); end
    endtask

    task automatic test_falla;
        for (int i = 0; i < 4; i++) muestra(510);
        n_cmp++; if (estado !== 3'd2) begin n_err++; $display("FAIL falla_pre_alta got=%0d exp=2", estado); end
        muestra(900);
        n_cmp++; if (estado !== 3'd5 || falla_sensor !== 1'b1 || alarma_alta !== 1'b0) begin n_err++; $display("FAIL falla_900 got=%0d/%b/%b exp=5/1/0", estado, falla_sensor, alarma_alta); end
        muestra(300); muestra(300); muestra(300); muestra(-401);
        n_cmp++; if (estado !== 3'd5 || falla_sensor !== 1'b1) begin n_err++; $display("FAIL falla_m401 got=%0d/%b exp=5/1", estado, falla_sensor); end
        for (int i = 1; i <= 3; i++) begin
            muestra(300);
            n_cmp++; if (estado !== 3'd5) begin n_err++; $display("FAIL falla_rec_%0d got=%0d exp=5", i, estado); end
        end
        muestra(300);
        n_cmp++; if (estado !== 3'd0 || falla_sensor !== 1'b0) begin n_err++; $display("FAIL falla_rec_4 got=%0d/%b exp=0/0", estado, falla_sensor); end
    endtask

    task automatic test_reset_medio;
        muestra(510); muestra(510); muestra(510);
        #3 arst_n = 1'b0;
        #1;
        n_cmp++; if (estado !== 3'd0 || {alarma_alta, alarma_baja, falla_sensor} !== 3'b000) begin n_err++; $display("FAIL rst_medio_estado got=%0d/%b exp=0/000", estado, {alarma_alta, alarma_baja, falla_sensor}); end
        n_cmp++; if (temp_max !== 11'sd220 || temp_min !== 11'sd220) begin n_err++; $display("FAIL rst_medio_extremos got=%0d/%0d exp=220/220", temp_max, temp_min); end
        @(posedge clk); #1 arst_n = 1'b1;
        muestra(510); muestra(510); muestra(510);
        n_cmp++; if (estado !== 3'd1 || alarma_alta !== 1'b0) begin n_err++; $display("FAIL rst_cnt_descartado got=%0d/%b exp=1/0", estado, alarma_alta); end
        muestra(510);
        n_cmp++; if (estado !== 3'd2 || alarma_alta !== 1'b1) begin n_err++; $display("FAIL rst_cnt_4 got=%0d/%b exp=2/1", estado, alarma_alta); end
    endtask

    task automatic test_extremos;
        #3 arst_n = 1'b0;
        @(posedge clk); #1 arst_n = 1'b1;
        muestra(220); muestra(-150); muestra(600); muestra(900);
        n_cmp++; if (temp_max !== 11'sd600 || temp_min !== -11'sd150) begin n_err++; $display("FAIL extremos_seq got=%0d/%0d exp=600/-150", temp_max, temp_min); end
        n_cmp++; if (estado !== 3'd5) begin n_err++; $display("FAIL extremos_seq_estado got=%0d exp=5", estado); end
        borrar_extremos = 1'b1; temp_in = temp_t'(300);
        @(posedge clk); #1;
        n_cmp++; if (temp_max !== 11'sd300 || temp_min !== 11'sd300) begin n_err++; $display("FAIL borrar_300 got=%0d/%0d exp=300/300", temp_max, temp_min); end
        muestra(900);
        n_cmp++; if (temp_max !== 11'sd220 || temp_min !== 11'sd220) begin n_err++; $display("FAIL borrar_900 got=%0d/%0d exp=220/220", temp_max, temp_min); end
        muestra(-400);
        borrar_extremos = 1'b0;
        n_cmp++; if (temp_max !== -11'sd400 || temp_min !== -11'sd400 || estado !== 3'd5) begin n_err++; $display("FAIL borrar_m400 got=%0d/%0d/%0d exp=-400/-400/5", temp_max, temp_min, estado); end
    endtask

    task automatic test_gating;
        temp_in = temp_t'(700);
        muestra_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (estado !== 3'd5 || falla_sensor !== 1'b1 || temp_max !== -11'sd400 || temp_min !== -11'sd400) begin n_err++; $display("FAIL gating_%0d got=%0d/%b/%0d/%0d exp=5/1/-400/-400", i, estado, falla_sensor, temp_max, temp_min); end
        end
        muestra(850); muestra(850);
        n_cmp++; if (estado !== 3'd5) begin n_err++; $display("FAIL limite_850_cnt got=%0d exp=5", estado); end
        muestra(850);
        n_cmp++; if (estado !== 3'd0 || falla_sensor !== 1'b0) begin n_err++; $display("FAIL limite_850_rec got=%0d/%b exp=0/0", estado, falla_sensor); end
        n_cmp++; if (temp_max !== 11'sd850 || temp_min !== -11'sd400) begin n_err++; $display("FAIL limite_850_ext got=%0d/%0d exp=850/-400", temp_max, temp_min); end
    endtask

    initial begin
        test_reset;
        test_confirmacion;
        test_histeresis;
        test_aborto;
        test_baja;
        test_falla;
        test_reset_medio;
        test_extremos;
        test_gating;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alarma_temp.md
# alarma_temp

Alarm monitor sitting directly downstream of the temperature sample register. It consumes the registered signed temperature in tenths of °C (valid range −400…850). It raises high and low alarms with hysteresis and N-sample confirmation, flags out-of-range readings as a sensor fault, and tracks running maximum and minimum values. All outputs are registered and feed the display and communication stages.

## Interface
- UMBRAL_ALTO, default 500: high-alarm threshold in tenths of °C (50.0 °C).
- UMBRAL_BAJO, default 0: low-alarm threshold (0.0 °C).
- HISTERESIS, default 20: release margin (2.0 °C).
- N_CONFIRM, default 4: consecutive qualifying samples required. Legal range is 2…15.
- Parameter constraint, checked by elaboration assertion: −400 ≤ UMBRAL_BAJO, UMBRAL_BAJO+HISTERESIS < UMBRAL_ALTO−HISTERESIS, and UMBRAL_ALTO ≤ 850.

Ports:
- clk  in  1  system clock; single clock domain.
- arst_n  in  1  asynchronous reset, active low.
- muestra_en  in  1  one-cycle strobe; temp_in is evaluated only when this is high.
- temp_in  in  11 signed  registered temperature from the upstream stage.
- borrar_extremos  in  1  synchronous clear of the max/min trackers.
- alarma_alta  out  1  high when the state is ALTA.
- alarma_baja  out  1  high when the state is BAJA.
- falla_sensor  out  1  high when the state is FALLA.
- estado  out  3  current FSM state code.
- temp_max  out  11 signed  maximum in-range sample since the last clear.
- temp_min  out  11 signed  minimum in-range sample since the last clear.

## Operation
- Range check: a sample is in range when −400 ≤ temp_in ≤ 850. All comparisons are signed. Threshold±HISTERESIS is computed at 12-bit signed width, so no overflow is possible.
- FSM state codes: NORMAL=0, CONF_ALTA=1, ALTA=2, CONF_BAJA=3, BAJA=4, FALLA=5. A 4-bit counter `cnt` supports the confirmation states.
- The FSM updates only on a clock edge where muestra_en=1.
- Priority rule: an out-of-range sample sends any state to FALLA with cnt=0, ahead of every rule below.
- NORMAL:
  - temp_in ≥ UMBRAL_ALTO → CONF_ALTA, cnt=1.
  - temp_in ≤ UMBRAL_BAJO → CONF_BAJA, cnt=1.
  - Otherwise stay in NORMAL.
- CONF_ALTA:
  - Qualifying sample (≥ UMBRAL_ALTO): cnt+1; when cnt+1 = N_CONFIRM → ALTA, cnt=0.
  - Non-qualifying sample → NORMAL, cnt=0.
- CONF_BAJA: symmetric to CONF_ALTA, with qualifying meaning ≤ UMBRAL_BAJO, ending in BAJA.
- ALTA: temp_in < UMBRAL_ALTO−HISTERESIS → NORMAL immediately, with no confirmation. A sample at or below UMBRAL_BAJO still goes to NORMAL first.
- BAJA: temp_in > UMBRAL_BAJO+HISTERESIS → NORMAL immediately.
- FALLA:
  - In-range sample: cnt+1; when cnt+1 = N_CONFIRM → NORMAL, cnt=0.
  - Out-of-range sample: cnt=0, stay in FALLA.
- Alarm outputs are decoded from the state register, so they are glitch-free.
- Extremes tracker:
  - On muestra_en with an in-range sample: temp_max ← max(temp_max, temp_in) and temp_min ← min(temp_min, temp_in).
  - Out-of-range samples are ignored.
  - borrar_extremos=1 loads both trackers with temp_in if it is in range, otherwise with 220.
  - borrar_extremos overrides a simultaneous muestra_en for the trackers only; the FSM still processes the sample.

## Timing
- Reset (arst_n low, asynchronous):
  - estado=NORMAL, cnt=0.
  - alarma_alta, alarma_baja and falla_sensor are 0.
  - temp_max=temp_min=220, matching the upstream reset value.
- Reset mid-operation discards any partial confirmation count.
- Latency: the N_CONFIRM-th qualifying sample is registered at edge k. estado and the alarm output change immediately after edge k.
- Release and fault entry take effect after the edge on which the triggering sample is taken.
- Extremes reflect a sample immediately after its edge.
- When muestra_en=0, all state holds regardless of temp_in; only borrar_extremos can act.

## Structure
- Shared package temp_pkg contains:
  - `temp_t` (logic signed [10:0]).
  - TEMP_MIN=−400, TEMP_MAX=850, TEMP_RESET=220.
  - `estado_alarma_t` enum with the codes listed above.
- The upstream register also adopts temp_pkg.
- One sub-module, `registro_extremos`, holds the max/min tracker with its clear logic. The FSM and counter stay in `alarma_temp`.

## Test plan
All scenarios use the default parameters.
- Reset: assert arst_n low mid-run → estado=0 and all flags 0 with no clock edge required; temp_max=temp_min=220.
- Confirmation:
  - Four strobed samples of 510 → alarma_alta=1 after the 4th edge.
  - 510, 510, 510, then 490 → estado=0 and alarma_alta never asserts.
- Hysteresis: from ALTA, a sample of 485 keeps ALTA; 480 keeps ALTA; 479 → NORMAL and alarma_alta=0 after that edge.
- Low side: four samples of −5 → BAJA; a sample of 20 holds BAJA; 21 → NORMAL.
- Fault: in ALTA, a sample of 900 → estado=5, falla_sensor=1, alarma_alta=0.
  - Then 3 in-range samples plus −401 → stays in FALLA.
  - Then 4 samples of 300 → NORMAL.
- Extremes and gating:
  - Samples 220, −150, 600, 900 → temp_max=600, temp_min=−150.
  - borrar_extremos with temp_in=300 → both trackers 300.
  - temp_in=700 held for 10 cycles with muestra_en=0 → no output changes.
